// File: rtl/regfile_mp.sv
// regfile_mp: multi-port LEGv8 register file, two prioritised write ports, optional bypass; REGFILE_SCOREBOARD_EN adds a busy scoreboard
module regfile_mp #(
  parameter int WIDTH   = 64,
  parameter int ADDRW   = 5,
  parameter int NREAD   = 2,
  parameter int ZEROREG = 31,
  parameter int BYPASS  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD*ADDRW-1:0] ra,
  output logic [NREAD*WIDTH-1:0] rdata,
  input  logic                   we0,
  input  logic [ADDRW-1:0]       wa0,
  input  logic [WIDTH-1:0]       wd0,
  input  logic                   we1,
  input  logic [ADDRW-1:0]       wa1,
  input  logic [WIDTH-1:0]       wd1
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                   alloc,
  input  logic [ADDRW-1:0]       alloc_a,
  output logic [NREAD-1:0]       rbusy
`endif
);
  localparam int DEPTH = 2 ** ADDRW;
  localparam logic [31:0] ZR = 32'(ZEROREG);
  function automatic logic is_zr(input logic [ADDRW-1:0] a);
    return 32'(a) == ZR;
  endfunction
  logic             w0_en, w1_en;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  assign w0_en = we0 && !is_zr(wa0);
  assign w1_en = we1 && !is_zr(wa1);
  // next contents: port 1 overrides port 0 on an address collision
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++)
      mem_d[i] = (w1_en && wa1 == ADDRW'(i)) ? wd1 :
                 (w0_en && wa0 == ADDRW'(i)) ? wd0 : mem_q[i];
  end
  // storage with asynchronous clear; the zero register is never written so it stays 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else
      mem_q <= mem_d;
  end
`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] busy_q, busy_d;
  // a new allocation outranks a retiring write to the same register
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++)
      busy_d[i] = is_zr(ADDRW'(i)) ? 1'b0 :
                  (alloc && alloc_a == ADDRW'(i)) ? 1'b1 :
                  ((w1_en && wa1 == ADDRW'(i)) || (w0_en && wa0 == ADDRW'(i))) ? 1'b0 : busy_q[i];
  end
  // busy vector, cleared with the rest of the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end
`endif
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDRW-1:0] a;
    logic             hit0, hit1;
    assign a    = ra[k*ADDRW +: ADDRW];
    assign hit1 = (BYPASS != 0) && w1_en && wa1 == a;
    assign hit0 = (BYPASS != 0) && w0_en && wa0 == a;
    assign rdata[k*WIDTH +: WIDTH] = (reset || is_zr(a)) ? '0 :
                                     hit1 ? wd1 : hit0 ? wd0 : mem_q[a];
`ifdef REGFILE_SCOREBOARD_EN
    assign rbusy[k] = busy_q[a];
`endif
  end
endmodule
